accu_fifo: RTL and testbench
============================

# accu_fifo

Buffers window sums from the accumulator unit and hands them to downstream logic over a valid/ready read port. The accumulator has no back-pressure input. This block therefore captures each sum on the rising edge of the accumulator's `data_valid`, stores it in a circular buffer, and drops it if the buffer is full. Dropped sums set a sticky overflow flag and increment a saturating drop counter.

## Interface

**Parameters**
- `data_width`, default 38: sum width; equals accumulator `input_width`+1.
- `depth`, default 16: buffer entries; must be a power of two.
- `addr_width`, default 4: log2(`depth`).

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_data` in `data_width`: signed sum from the accumulator `dout`.
- `wr_valid` in 1: accumulator `data_valid`; may stay high for several cycles.
- `rd_data` out `data_width`: signed head-of-queue word.
- `rd_valid` out 1: `rd_data` holds a valid word.
- `rd_ready` in 1: consumer accepts `rd_data` this cycle.
- `level` out `addr_width`+1: number of stored words, 0..`depth`.
- `full` out 1: `level` == `depth`.
- `empty` out 1: `level` == 0.
- `overflow` out 1: sticky; set when a sum is dropped.
- `ovf_clr` in 1: synchronous clear of `overflow` and `drop_cnt`.
- `drop_cnt` out 8: number of dropped sums; saturates at 255.

## Operation

**Write strobe**
- A registered copy of `wr_valid` (`wv_q`) is kept.
- Write strobe `wr_stb` = `wr_valid` & ~`wv_q`.
- Exactly one capture happens per high period of `wr_valid`, however long the accumulator holds it.

**Read**
- Read fire `rd_fire` = `rd_valid` & `rd_ready`.
- `rd_valid` = ~`empty`.
- `rd_data` = mem[`rd_ptr`], driven combinationally from the storage array (show-ahead).
- When `empty`, `rd_data` holds the last addressed location; its value is don't-care.

**Write accept**
- A write is accepted when `wr_stb` & (~`full` | `rd_fire`).
- Full with a same-cycle read: the read frees a slot, so the write is accepted and `level` is unchanged.

**Drop**
- A drop occurs when `wr_stb` & `full` & ~`rd_fire`.
- On a drop: the word is discarded, `overflow` is set to 1, and `drop_cnt` increments unless it is at 255.

**Pointers and level**
- `wr_ptr` and `rd_ptr` are `addr_width` bits wide and wrap modulo `depth`.
- On accept: `wr_ptr`+1. On read fire: `rd_ptr`+1.
- `level` changes by +1 (write only), -1 (read only), or 0 (both or neither).

**Data handling**
- Data is stored bit-exact; there is no sign extension or truncation.

**Overflow clear**
- `ovf_clr` has priority over a same-cycle drop: the counter clears to 0 and `overflow` to 0, and that cycle's drop is not counted.

**Reset**
- Reset is asynchronous and takes effect immediately, mid-operation included.
- Pointers, `level`, `wv_q`, `overflow` and `drop_cnt` go to 0.
- `empty`=1, `full`=0, `rd_valid`=0.
- Stored contents are not cleared and are unreadable until rewritten.
- `wv_q` resets to 0. If `wr_valid` is already high as reset releases, one capture occurs on the first edge after release.

## Timing

**Write latency**
- If `wr_stb` is sampled at edge N into an empty buffer, then after edge N: `rd_valid`=1, `rd_data`=captured word, `level`=1.
- Latency is one cycle.

**Read latency**
- A read fire at edge N advances `rd_ptr`; the next word (or `rd_valid`=0) appears after edge N.
- Zero-bubble back-to-back reads are supported.

**Registered outputs**
- `full`, `empty`, `level`, `overflow` and `drop_cnt` are registered, or derived purely from registered state; they update after the edge.

**Combinational paths**
- There is no combinational path from `wr_valid` or `wr_data` to any output.
- There is no combinational path from `rd_ready` to any output.

**Handshake rules**
- `rd_valid` is never deasserted without a read fire, except by reset.
- `rd_data` is stable while `rd_valid` & ~`rd_ready`.

**Throughput**
- Writes: at most one per two cycles, because of edge detection.
- Reads: one per cycle.

## Test plan

1. **Reset and empty read:** hold `rst` high, release, hold `rd_ready`=1 for 5 cycles -> `rd_valid`=0, `empty`=1, `level`=0, `overflow`=0, `drop_cnt`=0 throughout.
2. **Held strobe:** hold `wr_valid` high for 4 cycles with `wr_data`=-5 -> exactly one capture; `level`=1; `rd_data`=-5 (38-bit two's complement) one cycle after the rising edge.
3. **Fill and wrap:** write 16 sums 1..16 with `rd_ready`=0 -> `full`=1, `level`=16. Then set `rd_ready`=1 -> reads return 1..16 in order on consecutive cycles. Then write 17..20 -> they read back in order with correct pointer wrap.
4. **Overflow:** with the buffer full and `rd_ready`=0, issue 3 more strobes -> `overflow`=1, `drop_cnt`=3, stored data unchanged. Then pulse `ovf_clr` -> `overflow`=0, `drop_cnt`=0.
5. **Full with same-cycle read:** with the buffer full, assert `rd_ready`=1 in the same cycle as `wr_stb` carrying 99 -> no drop, `level` stays 16, and 99 is read out last.
6. **Reset mid-stream:** with `level`=7, assert `rst` asynchronously between clock edges -> `rd_valid`, `level` and `full` drop immediately. After release, writing 42 -> `rd_data`=42 is the first word read.

Source files
------------

// File: rtl/accu_fifo.sv
// rtl/accu_fifo.sv - edge-captured circular buffer for accumulator window sums
// One capture per wr_valid high period; sums arriving while full are dropped and counted.
module accu_fifo #(
  parameter int data_width = 38,
  parameter int depth      = 16,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_valid,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [addr_width:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            drop_cnt
);

  localparam logic [addr_width:0] full_lvl = (addr_width+1)'(depth);

  logic [data_width-1:0] mem [depth];

  logic                  wv_q, wv_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic wr_stb, rd_fire, wr_acc, drop;

  assign full     = (level_q == full_lvl);
  assign empty    = (level_q == '0);
  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr_q];
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    wv_d       = wr_valid;
    wr_stb     = wr_valid & ~wv_q;
    rd_fire    = rd_valid & rd_ready;
    // A read in the same cycle frees the slot the write needs.
    wr_acc     = wr_stb & (~full | rd_fire);
    drop       = wr_stb & full & ~rd_fire;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + addr_width'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + addr_width'(1);

    case ({wr_acc, rd_fire})
      2'b10:   level_d = level_q + (addr_width+1)'(1);
      2'b01:   level_d = level_q - (addr_width+1)'(1);
      default: level_d = level_q;
    endcase

    // Clearing wins over a drop in the same cycle.
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wv_q       <= wv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_accu_fifo.sv
// tb/tb_accu_fifo.sv - directed self-checking bench for accu_fifo
// Inputs change and outputs are sampled on the falling clock edge.
module tb_accu_fifo;

  logic        clk;
  logic        rst;
  logic [37:0] wr_data;
  logic        wr_valid;
  logic [37:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  accu_fifo #(.data_width(38), .depth(16), .addr_width(4)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .level(level), .full(full), .empty(empty),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [37:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] neg5;
    neg5     = 38'h3F_FFFF_FFFB;
    rst      = 1'b1;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state and reads from empty
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_level", 64'(level), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      tick();
    end
    rd_ready = 1'b0;

    // 2: long wr_valid captures once
    wr_data  = neg5;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_level", 64'(level), 64'd1);
      check("held_data", 64'(rd_data), 64'(neg5));
    end
    check("held_rd_valid", 64'(rd_valid), 64'd1);
    wr_valid = 1'b0;
    tick();
    rd_ready = 1'b1;
    tick();
    check("held_drain_empty", 64'(empty), 64'd1);
    rd_ready = 1'b0;

    // 3: fill, drain across the pointer wrap, then more writes
    for (int i = 1; i <= 16; i++) write_word(38'(i));
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd16);
    check("fill_head", 64'(rd_data), 64'd1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("fill_rd_valid", 64'(rd_valid), 64'd1);
      check("fill_rd_data", 64'(rd_data), 64'(i));
      tick();
    end
    check("fill_drained", 64'(empty), 64'd1);
    rd_ready = 1'b0;
    for (int i = 17; i <= 20; i++) write_word(38'(i));
    check("wrap_level", 64'(level), 64'd4);
    rd_ready = 1'b1;
    for (int i = 17; i <= 20; i++) begin
      check("wrap_rd_data", 64'(rd_data), 64'(i));
      tick();
    end
    check("wrap_empty", 64'(empty), 64'd1);
    rd_ready = 1'b0;

    // 4: overflow, counter, clear, saturation
    for (int i = 0; i < 16; i++) write_word(38'(100 + i));
    for (int i = 0; i < 3; i++) write_word(38'd200);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_cnt", 64'(drop_cnt), 64'd3);
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_head", 64'(rd_data), 64'd100);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_flag", 64'(overflow), 64'd0);
    check("clr_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 260; i++) write_word(38'd300);
    check("sat_cnt", 64'(drop_cnt), 64'd255);
    check("sat_flag", 64'(overflow), 64'd1);
    // clear coinciding with a drop: the drop is not counted
    wr_data  = 38'd301;
    wr_valid = 1'b1;
    ovf_clr  = 1'b1;
    tick();
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    check("clr_prio_cnt", 64'(drop_cnt), 64'd0);
    check("clr_prio_flag", 64'(overflow), 64'd0);
    check("clr_prio_level", 64'(level), 64'd16);

    // 5: write while full with a simultaneous read
    wr_data  = 38'd99;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("fullrw_level", 64'(level), 64'd16);
    check("fullrw_ovf", 64'(overflow), 64'd0);
    check("fullrw_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 1; i <= 15; i++) begin
      check("fullrw_data", 64'(rd_data), 64'(100 + i));
      tick();
    end
    check("fullrw_last", 64'(rd_data), 64'd99);
    check("fullrw_last_valid", 64'(rd_valid), 64'd1);
    tick();
    check("fullrw_empty", 64'(empty), 64'd1);
    rd_ready = 1'b0;

    // 6: asynchronous reset between edges
    for (int i = 0; i < 7; i++) write_word(38'(500 + i));
    check("mid_level", 64'(level), 64'd7);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    write_word(38'd42);
    check("post_rst_valid", 64'(rd_valid), 64'd1);
    check("post_rst_data", 64'(rd_data), 64'd42);
    check("post_rst_level", 64'(level), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
